// File: rtl/matrix_scanner_pkg.sv
// Shared constants and drive-level helpers for the LED matrix scanner.
package matrix_scanner_pkg;

    localparam int DEF_ROWS  = 4;
    localparam int DEF_COLS  = 4;
    localparam int DEF_DWELL = 16;
    localparam int DEF_BLANK = 2;
    localparam bit DEF_ROW_ACTIVE_LOW  = 1'b1;
    localparam bit DEF_COL_ACTIVE_HIGH = 1'b1;

    // Pin level for a row driver given whether the row is selected.
    function automatic logic row_level(input logic active, input logic active_low);
        return active_low ? ~active : active;
    endfunction

    // Pin level of an unselected row.
    function automatic logic row_inactive(input logic active_low);
        return row_level(1'b0, active_low);
    endfunction

    // Pin level for a column driver given whether the pixel is lit.
    function automatic logic col_level(input logic lit, input logic active_high);
        return active_high ? lit : ~lit;
    endfunction

    // Pin level of a dark column.
    function automatic logic col_inactive(input logic active_high);
        return col_level(1'b0, active_high);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N counter with synchronous clear; wrap flags the terminal count step.
module mod_counter #(
    parameter int N     = 4,
    parameter int width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [width-1:0] cnt,
    output logic             wrap
);

    localparam logic [width-1:0] LAST = width'(N - 1);

    logic [width-1:0] cnt_q;
    logic [width-1:0] cnt_d;

    // Next count: clear wins, otherwise step and fold back to zero after LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + width'(1'b1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = en & ~clr & (cnt_q == LAST);

endmodule

// File: rtl/matrix_scanner.sv
// Row-multiplexed LED matrix driver: one row per DWELL-cycle slot, leading
// blanking, brightness as a lit-cycle count, frame image latched per frame.
module matrix_scanner
    import matrix_scanner_pkg::*;
#(
    parameter int ROWS            = DEF_ROWS,
    parameter int COLS            = DEF_COLS,
    parameter int DWELL           = DEF_DWELL,
    parameter int BLANK           = DEF_BLANK,
    parameter bit ROW_ACTIVE_LOW  = DEF_ROW_ACTIVE_LOW,
    parameter bit COL_ACTIVE_HIGH = DEF_COL_ACTIVE_HIGH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [ROWS*COLS-1:0]         pixels,
    input  logic [$clog2(DWELL+1)-1:0]   bright,
    output logic [ROWS-1:0]              rows,
    output logic [COLS-1:0]              cols,
    output logic                         frame_start
);

    localparam int BW = $clog2(DWELL + 1);
    localparam int SW = $clog2(DWELL);
    localparam int RW = $clog2(ROWS);
    localparam logic [BW-1:0] BLANK_W   = BW'(BLANK);
    localparam logic [BW-1:0] LIT_MAX_W = BW'(DWELL - BLANK);

    logic [SW-1:0]        slot_s;
    logic [RW-1:0]        row_s;
    logic                 slot_wrap_s;
    logic                 frame_wrap_s;
    logic                 run_s;
    logic                 capture_s;
    logic [ROWS*COLS-1:0] pix_q;
    logic [ROWS*COLS-1:0] pix_d;
    logic [BW-1:0]        bright_q;
    logic [BW-1:0]        bright_d;
    logic [BW-1:0]        lit_cnt_s;
    logic [BW-1:0]        slot_ext_s;
    logic [BW-1:0]        lit_end_s;
    logic                 lit_s;
    logic [COLS-1:0]      pix_row_s [ROWS];

    // Disabling the scan parks both counters at row 0 / slot 0 so the next
    // enabled cycle starts a fresh frame.
    mod_counter #(.N(DWELL), .width(SW)) u_slot_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (~enable),
        .en   (enable),
        .cnt  (slot_s),
        .wrap (slot_wrap_s)
    );

    mod_counter #(.N(ROWS), .width(RW)) u_row_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (~enable),
        .en   (slot_wrap_s),
        .cnt  (row_s),
        .wrap (frame_wrap_s)
    );

    assign run_s     = enable & ~rst;
    assign capture_s = enable & (row_s == '0) & (slot_s == '0);

    // Shadow next-state: latch the image and brightness only at frame start.
    always_comb begin
        pix_d    = pix_q;
        bright_d = bright_q;
        if (capture_s) begin
            pix_d    = pixels;
            bright_d = bright;
        end else begin
            pix_d    = pix_q;
            bright_d = bright_q;
        end
    end

    // Shadow registers holding the frame being displayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q    <= '0;
            bright_q <= '0;
        end else begin
            pix_q    <= pix_d;
            bright_q <= bright_d;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_pix_row
        assign pix_row_s[r] = pix_q[r*COLS +: COLS];
    end

    // Lit window [BLANK, BLANK+L), L saturated so the window never runs past DWELL.
    always_comb begin
        lit_cnt_s  = (bright_q > LIT_MAX_W) ? LIT_MAX_W : bright_q;
        slot_ext_s = BW'(slot_s);
        lit_end_s  = BLANK_W + lit_cnt_s;
        lit_s      = (slot_ext_s >= BLANK_W) && (slot_ext_s < lit_end_s);
    end

    // Pin drive: select the current row and its column pattern only inside the window.
    always_comb begin
        rows = {ROWS{row_inactive(ROW_ACTIVE_LOW)}};
        cols = {COLS{col_inactive(COL_ACTIVE_HIGH)}};
        if (run_s && lit_s) begin
            rows[row_s] = row_level(1'b1, ROW_ACTIVE_LOW);
            for (int c = 0; c < COLS; c++) begin
                cols[c] = col_level(pix_row_s[row_s][c], COL_ACTIVE_HIGH);
            end
        end else begin
            rows = {ROWS{row_inactive(ROW_ACTIVE_LOW)}};
            cols = {COLS{col_inactive(COL_ACTIVE_HIGH)}};
        end
    end

    assign frame_start = run_s & (row_s == '0) & (slot_s == '0);

endmodule

// File: tb/tb_matrix_scanner.sv
// Self-checking bench for matrix_scanner: default-polarity and inverted-polarity
// instances share stimulus; expectations come from a frame-position model.
module tb_matrix_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DWELL = 16;
    localparam int BLANK = 2;
    localparam int FRAME = ROWS * DWELL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [15:0] pixels = 16'h0000;
    logic [4:0]  bright = 5'd0;
    logic [3:0]  rows, cols, rows_inv, cols_inv;
    logic        frame_start, frame_start_inv;

    int checks   = 0;
    int failures = 0;

    // Reference model: position inside the frame plus the latched frame image.
    int          m_pos    = 0;
    logic [15:0] m_pix    = 16'h0000;
    int          m_bright = 0;

    always #5 clk = ~clk;

    matrix_scanner dut (
        .clk(clk), .rst(rst), .enable(enable), .pixels(pixels), .bright(bright),
        .rows(rows), .cols(cols), .frame_start(frame_start)
    );

    matrix_scanner #(.ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_HIGH(1'b0)) dut_inv (
        .clk(clk), .rst(rst), .enable(enable), .pixels(pixels), .bright(bright),
        .rows(rows_inv), .cols(cols_inv), .frame_start(frame_start_inv)
    );

    function automatic logic [17:0] observed();
        return {rows, cols, frame_start, rows_inv, cols_inv, frame_start_inv};
    endfunction

    function automatic logic [17:0] model_expect();
        logic [3:0] r, c, ri, ci;
        logic fs;
        int row, slot, lit_n;
        r = 4'b1111; c = 4'b0000; ri = 4'b0000; ci = 4'b1111; fs = 1'b0;
        if (!rst && enable) begin
            row   = m_pos / DWELL;
            slot  = m_pos % DWELL;
            lit_n = (m_bright > DWELL - BLANK) ? DWELL - BLANK : m_bright;
            fs    = (m_pos == 0);
            if (slot >= BLANK && slot < BLANK + lit_n) begin
                r[row]  = 1'b0;
                ri[row] = 1'b1;
                for (int k = 0; k < COLS; k++) begin
                    c[k]  = m_pix[row*COLS + k];
                    ci[k] = ~m_pix[row*COLS + k];
                end
            end
        end
        return {r, c, fs, ri, ci, fs};
    endfunction

    task automatic model_update();
        if (rst) begin
            m_pos = 0; m_pix = 16'h0000; m_bright = 0;
        end else if (!enable) begin
            m_pos = 0;
        end else begin
            if (m_pos == 0) begin
                m_pix    = pixels;
                m_bright = int'(bright);
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    // Advance one clock: model follows the edge, bench returns at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic align_to(input int target);
        for (int i = 0; i < FRAME && m_pos != target; i++) cycle();
    endtask

    task automatic test_reset();
        logic [17:0] obs, exp;
        rst = 1'b1; enable = 1'b1; pixels = 16'($urandom()); bright = 5'd14;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({rows, cols, frame_start} !== {4'b1111, 4'b0000, 1'b0}) begin
                failures++;
                $display("FAIL reset_levels got=%b_%b_%b want=1111_0000_0", rows, cols, frame_start);
            end
            checks++;
            if ({rows_inv, cols_inv, frame_start_inv} !== {4'b0000, 4'b1111, 1'b0}) begin
                failures++;
                $display("FAIL reset_levels_inv got=%b_%b_%b want=0000_1111_0", rows_inv, cols_inv, frame_start_inv);
            end
            cycle();
        end
        rst = 1'b0;
        for (int k = 0; k < 2 * FRAME + 1; k++) begin
            #1;
            checks++;
            if (frame_start !== ((k % FRAME) == 0)) begin
                failures++;
                $display("FAIL reset_fs_period k=%0d got=%b want=%b", k, frame_start, (k % FRAME) == 0);
            end
            obs = observed(); exp = model_expect(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_model t=%0t got=%h want=%h", $time, obs, exp);
            end
            cycle();
        end
    endtask

    task automatic test_pattern();
        logic [3:0]  tbl_r [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [3:0]  tbl_c [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [17:0] obs, exp;
        int row, slot;
        pixels = 16'h8421; bright = 5'd14;
        align_to(0);
        for (int i = 0; i < FRAME; i++) begin
            #1;
            row = i / DWELL; slot = i % DWELL;
            checks++;
            if (slot >= BLANK) begin
                if ({rows, cols} !== {tbl_r[row], tbl_c[row]}) begin
                    failures++;
                    $display("FAIL pattern_lit r=%0d s=%0d got=%b_%b want=%b_%b", row, slot, rows, cols, tbl_r[row], tbl_c[row]);
                end
            end else begin
                if ({rows, cols} !== {4'b1111, 4'b0000}) begin
                    failures++;
                    $display("FAIL pattern_blank r=%0d s=%0d got=%b_%b want=1111_0000", row, slot, rows, cols);
                end
            end
            obs = observed(); exp = model_expect(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL pattern_model t=%0t got=%h want=%h", $time, obs, exp);
            end
            cycle();
        end
    endtask

    task automatic test_bright();
        int          vals [6];
        int          lit_cycles, want;
        logic [17:0] obs, exp;
        vals = '{5, 16, 0, 14, 1, int'($urandom_range(0, 16))};
        for (int v = 0; v < 6; v++) begin
            pixels = 16'($urandom()) | 16'h1111;
            bright = 5'(vals[v]);
            align_to(0);
            lit_cycles = 0;
            for (int i = 0; i < FRAME; i++) begin
                #1;
                if (rows !== 4'b1111) lit_cycles++;
                obs = observed(); exp = model_expect(); checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL bright_model b=%0d t=%0t got=%h want=%h", vals[v], $time, obs, exp);
                end
                cycle();
            end
            want = ROWS * ((vals[v] > DWELL - BLANK) ? DWELL - BLANK : vals[v]);
            checks++;
            if (lit_cycles != want) begin
                failures++;
                $display("FAIL bright_lit_count b=%0d got=%0d want=%0d", vals[v], lit_cycles, want);
            end
        end
    endtask

    task automatic test_midframe_change();
        logic [17:0] obs, exp;
        pixels = 16'hFFFF; bright = 5'd14;
        align_to(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i == 20) pixels = 16'h0000;
            #1;
            if ((i % DWELL) >= BLANK) begin
                checks++;
                if (cols !== ((i < FRAME) ? 4'b1111 : 4'b0000)) begin
                    failures++;
                    $display("FAIL midframe_cols i=%0d got=%b want=%b", i, cols, (i < FRAME) ? 4'b1111 : 4'b0000);
                end
            end
            obs = observed(); exp = model_expect(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL midframe_model t=%0t got=%h want=%h", $time, obs, exp);
            end
            cycle();
        end
    endtask

    task automatic test_enable_drop();
        logic [17:0] obs, exp;
        logic [15:0] p2;
        pixels = 16'($urandom()); bright = 5'd14;
        align_to(0);
        align_to(2 * DWELL + 7);
        enable = 1'b0;
        p2 = 16'($urandom()) ^ 16'h5A5A;
        pixels = p2;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rows, cols, frame_start, rows_inv, cols_inv} !== {4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111}) begin
                failures++;
                $display("FAIL endrop_idle i=%0d got=%b_%b_%b want=1111_0000_0", i, rows, cols, frame_start);
            end
            cycle();
        end
        enable = 1'b1;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL endrop_restart_fs got=%b want=1", frame_start);
        end
        for (int i = 0; i < FRAME; i++) begin
            #1;
            if (i == BLANK) begin
                checks++;
                if ({rows, cols} !== {4'b1110, p2[3:0]}) begin
                    failures++;
                    $display("FAIL endrop_capture got=%b_%b want=1110_%b", rows, cols, p2[3:0]);
                end
            end
            obs = observed(); exp = model_expect(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL endrop_model t=%0t got=%h want=%h", $time, obs, exp);
            end
            cycle();
        end
    endtask

    task automatic test_rst_midframe();
        logic [17:0] obs, exp;
        pixels = 16'($urandom()); bright = 5'd9;
        align_to(30);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({rows, cols, frame_start} !== {4'b1111, 4'b0000, 1'b0}) begin
                failures++;
                $display("FAIL rstmid_idle got=%b_%b_%b want=1111_0000_0", rows, cols, frame_start);
            end
            cycle();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (frame_start !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_restart_fs got=%b want=1", frame_start);
        end
        for (int i = 0; i < FRAME + 8; i++) begin
            #1;
            obs = observed(); exp = model_expect(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rstmid_model t=%0t got=%h want=%h", $time, obs, exp);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        logic [17:0] obs, exp;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) pixels = 16'($urandom());
            if ($urandom_range(0, 19) == 0) bright = 5'($urandom_range(0, 16));
            enable = ($urandom_range(0, 49) != 0);
            rst    = ($urandom_range(0, 199) == 0);
            #1;
            obs = observed(); exp = model_expect(); checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL random_model t=%0t got=%h want=%h", $time, obs, exp);
            end
            cycle();
        end
        rst = 1'b0; enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_bright();
        test_midframe_change();
        test_enable_drop();
        test_rst_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_scanner.md
MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of matrix rows (>=2).
REQ-002 Parameter COLS, default 4, number of matrix columns (>=1).
REQ-003 Parameter DWELL, default 16, clock cycles per row slot (> BLANK).
REQ-004 Parameter BLANK, default 2, leading blanked cycles per row slot (>=1).
REQ-005 Parameter ROW_ACTIVE_LOW, default 1, the selected row is driven 0 when set, 1 when clear.
REQ-006 Parameter COL_ACTIVE_HIGH, default 1, a lit column is driven 1 when set, 0 when clear.
REQ-007 clk  in  1  system clock; all state updates on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  scanning enabled when high.
REQ-010 pixels  in  ROWS*COLS  frame image; bit r*COLS+c is row r, column c.
REQ-011 bright  in  BW = clog2(DWELL+1)  lit cycles per row slot.
REQ-012 rows  out  ROWS  row drivers.
REQ-013 cols  out  COLS  column drivers.
REQ-014 frame_start  out  1  high for exactly the row 0 / slot 0 cycle of each frame.

Function
REQ-015 Registered slot counter 0..DWELL-1 shall increment each enabled cycle; at DWELL-1 it shall wrap to 0 and advance the row index.
REQ-016 Registered row index 0..ROWS-1 shall wrap from ROWS-1 to 0, giving a frame period of ROWS*DWELL cycles.
REQ-017 On an enabled cycle with row==0 and slot==0, pixels and bright shall be captured into shadow registers used for the whole following frame.
REQ-018 Effective lit count L = min(bright_shadow, DWELL-BLANK); saturation shall be applied without wrap.
REQ-019 Slot in [BLANK, BLANK+L-1]: rows[row] active, all other rows inactive, cols[c] = shadow bit row*COLS+c mapped through COL_ACTIVE_HIGH.
REQ-020 All other slots, including 0..BLANK-1 and slots after the lit window: all rows inactive, all cols inactive.
REQ-021 rows, cols and frame_start shall be combinational functions of registered state, rst and enable only, with no direct path from pixels or bright.
REQ-022 frame_start = enable & ~rst & (row==0) & (slot==0).
REQ-023 When enable is low, row and slot shall load 0 on the next edge, shadows shall hold, and outputs shall be inactive with frame_start low in that same cycle.
REQ-024 The first enabled cycle after enable rises shall be row 0, slot 0, with a frame_start pulse and a fresh capture.
REQ-025 A pixels or bright change mid-frame shall have no effect until the next frame_start.
REQ-026 bright==0 shall never light any row.

Reset
REQ-027 While rst is high: row, slot, pixel shadow and bright shadow shall load 0 at the edge; rows and cols shall be inactive and frame_start low combinationally.
REQ-028 rst shall override enable; rst asserted mid-frame shall abort that frame, and the first cycle after release with enable high shall be a frame_start.

Structure
REQ-029 Package matrix_scanner_pkg shall hold the default parameter constants and the polarity-mapping helper functions for active and inactive row/column levels.
REQ-030 One sub-module, mod_counter (parameters N and width; ports clk, rst, clr, en, cnt, wrap), shall be instantiated twice: slot counter and row counter, the row counter enabled by the slot counter's wrap.

Verification (defaults ROWS=4, COLS=4, DWELL=16, BLANK=2, enable=1)
REQ-031 rst high 3 cycles, then released -> during reset rows=4'b1111, cols=4'b0000, frame_start=0; first cycle after release frame_start=1, then again every 64 cycles.
REQ-032 pixels=16'h8421, bright=14 -> row0 slots 2..15 rows=4'b1110 cols=4'b0001; row1 rows=4'b1101 cols=4'b0010; row2 4'b1011/4'b0100; row3 4'b0111/4'b1000; slots 0..1 blank.
REQ-033 bright=5 -> each row lit at slots 2..6 only; bright=16 -> lit at slots 2..15 (clipped to 14); bright=0 -> rows=4'b1111 for the whole frame.
REQ-034 pixels changed from 16'hFFFF to 16'h0000 at frame cycle 20 -> cols stay 4'b1111 on lit slots until the next frame_start, then 4'b0000.
REQ-035 enable dropped at row 2, slot 7 for 5 cycles -> outputs inactive in those cycles; on re-enable frame_start=1, row 0, and the current pixels are captured.
REQ-036 ROW_ACTIVE_LOW=0, COL_ACTIVE_HIGH=0 -> active row driven 1, lit columns driven 0; during reset rows=0 and cols all 1.
